carregador_de_instrucoes: RTL and testbench

Byte-serial loader that writes program words into the instruction memory. It is the write side of the instruction memory, which is otherwise read-only from the CPU.
- Receives a framed byte stream: sync byte, 16-bit word count, then words as 4 bytes each, MSB first.
- Emits one write pulse per assembled word, at consecutive addresses from 0.
- Holds the CPU idle while a load is in progress.

---
 rtl/carregador_pkg.sv | 17 +
 rtl/carregador_de_instrucoes_if.sv | 24 ++
 rtl/carregador_de_instrucoes_montador_de_palavra.sv | 34 +++
 rtl/carregador_de_instrucoes.sv | 94 +++++++++
 tb/tb_carregador_de_instrucoes.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/carregador_pkg.sv
// Shared definitions for the byte-serial instruction loader: FSM states and frame constants.
package carregador_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    WRITE,
    DONE,
    ERRO
  } estado_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_WORD    = 4;

endpackage

// File: rtl/carregador_de_instrucoes_if.sv
// Byte stream in, instruction-memory write port and status out, bundled for the loader.
interface carregador_de_instrucoes_if #(
  parameter int ADDR_WIDTH = 26
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  escrita_habilitada;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [31:0]           dado;
  logic                  ocupado;
  logic                  concluido;
  logic                  erro;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, escrita_habilitada, endereco, dado, ocupado, concluido, erro
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, escrita_habilitada, endereco, dado, ocupado, concluido, erro
  );
endinterface

// File: rtl/carregador_de_instrucoes_montador_de_palavra.sv
// Assembles 32-bit words from MSB-first bytes; flags the byte that completes a word.
module montador_de_palavra
  import carregador_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        limpar,
  input  logic        deslocar,
  input  logic [7:0]  byte_in,
  output logic [31:0] palavra_seguinte,
  output logic        palavra_pronta
);

  logic [31:0] palavra;
  logic [1:0]  indice;

  // Value the register takes once byte_in is shifted in; lets the caller capture the full word on the completing edge.
  assign palavra_seguinte = (palavra << 8) | {24'd0, byte_in};
  assign palavra_pronta   = deslocar && (indice == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      palavra <= '0;
      indice  <= '0;
    end else if (limpar) begin
      palavra <= '0;
      indice  <= '0;
    end else if (deslocar) begin
      palavra <= palavra_seguinte;
      indice  <= indice + 2'd1;
    end
  end

endmodule

// File: rtl/carregador_de_instrucoes.sv
// Framed byte-stream loader: sync byte, 16-bit word count, then words written to instruction memory.
module carregador_de_instrucoes
  import carregador_pkg::*;
#(
  parameter int         MEM_SIZE   = 30,
  parameter int         ADDR_WIDTH = 26,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input logic                      clock,
  input logic                      reset,
  carregador_de_instrucoes_if.slave bus
);

  estado_t               estado, proximo;
  logic                  aceito;
  logic [7:0]            len_hi;
  logic [15:0]           contagem;
  logic [15:0]           restante;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  limpar, deslocar, pronta;
  logic [31:0]           palavra_seguinte;

  assign bus.byte_ready = (estado != WRITE);
  assign aceito         = bus.byte_valid && bus.byte_ready;
  assign contagem       = {len_hi, bus.byte_in};
  assign limpar         = aceito && (estado == LEN_LO);
  assign deslocar       = aceito && (estado == WORD);

  assign bus.ocupado   = (estado == LEN_HI) || (estado == LEN_LO) ||
                         (estado == WORD)   || (estado == WRITE);
  assign bus.concluido = (estado == DONE);
  assign bus.erro      = (estado == ERRO);

  montador_de_palavra u_montador (
    .clock            (clock),
    .reset            (reset),
    .limpar           (limpar),
    .deslocar         (deslocar),
    .byte_in          (bus.byte_in),
    .palavra_seguinte (palavra_seguinte),
    .palavra_pronta   (pronta)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      IDLE, DONE, ERRO: if (aceito && bus.byte_in == SYNC_BYTE) proximo = LEN_HI;
      LEN_HI:           if (aceito) proximo = LEN_LO;
      LEN_LO: begin
        if (aceito) begin
          if (contagem == 16'd0)                proximo = DONE;
          else if (contagem > 16'(MEM_SIZE))    proximo = ERRO;
          else                                  proximo = WORD;
        end
      end
      WORD:             if (pronta) proximo = WRITE;
      // restante still holds the pre-decrement value during WRITE
      WRITE:            proximo = (restante == 16'd1) ? DONE : WORD;
      default:          proximo = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi                 <= '0;
      restante               <= '0;
      addr                   <= '0;
      bus.escrita_habilitada <= 1'b0;
      bus.endereco           <= '0;
      bus.dado               <= '0;
    end else begin
      bus.escrita_habilitada <= pronta;
      if (pronta) begin
        bus.endereco <= addr;
        bus.dado     <= palavra_seguinte;
      end
      if (aceito && estado == LEN_HI) len_hi <= bus.byte_in;
      if (limpar) begin
        restante <= contagem;
        addr     <= '0;
      end
      if (estado == WRITE) begin
        restante <= restante - 16'd1;
        addr     <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Directed and randomized frames checked against a frame-level model of the loader.
module tb_carregador_de_instrucoes;
  localparam int MEM_SIZE   = 30;
  localparam int ADDR_WIDTH = 26;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  carregador_de_instrucoes_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  carregador_de_instrucoes #(
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          stream_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the next expected (address, word) pair in order.
  always @(negedge clock) begin
    if (bus.escrita_habilitada === 1'b1) begin
      if (exp_addr.size() == 0) chk("strobe_unexpected", 64'd1, 64'd0);
      else begin
        chk("write_addr", 64'(bus.endereco), 64'(exp_addr.pop_front()));
        chk("write_data", 64'(bus.dado), 64'(exp_data.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int waited;
    gap = stream_mode ? 0 : int'($urandom_range(0, 2));
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    waited = 0;
    while (bus.byte_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clock);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] junk[$], input int count, input logic [31:0] w[$]);
    logic [15:0] cnt;
    logic [31:0] word;
    cnt = 16'(count);
    foreach (junk[k]) send_byte(junk[k]);
    if (junk.size() > 0) chk("junk_dropped_ocupado", 64'(bus.ocupado), 64'd0);
    send_byte(8'hA5);
    chk("sync_ocupado", 64'(bus.ocupado), 64'd1);
    chk("sync_clears_concluido", 64'(bus.concluido), 64'd0);
    chk("sync_clears_erro", 64'(bus.erro), 64'd0);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    if (count == 0) begin
      chk("zero_concluido", 64'(bus.concluido), 64'd1);
      chk("zero_ocupado", 64'(bus.ocupado), 64'd0);
    end else if (count > MEM_SIZE) begin
      chk("over_erro", 64'(bus.erro), 64'd1);
      chk("over_concluido", 64'(bus.concluido), 64'd0);
      chk("over_ocupado", 64'(bus.ocupado), 64'd0);
    end else begin
      for (int i = 0; i < count; i++) begin
        word = w[i];
        exp_addr.push_back(i);
        exp_data.push_back(word);
        for (int j = 3; j >= 0; j--) send_byte(word[8*j +: 8]);
        chk("strobe_latency", 64'(bus.escrita_habilitada), 64'd1);
        chk("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
        chk("ocupado_in_write", 64'(bus.ocupado), 64'd1);
      end
      @(negedge clock);
      chk("done_concluido", 64'(bus.concluido), 64'd1);
      chk("done_ocupado", 64'(bus.ocupado), 64'd0);
      chk("done_erro", 64'(bus.erro), 64'd0);
      chk("all_written", 64'(exp_addr.size()), 64'd0);
    end
  endtask

  initial begin
    logic [7:0]  junk[$];
    logic [31:0] words[$];
    logic [7:0]  b;
    int          kind, count;

    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_strobe", 64'(bus.escrita_habilitada), 64'd0);
    chk("rst_endereco", 64'(bus.endereco), 64'd0);
    chk("rst_dado", 64'(bus.dado), 64'd0);
    chk("rst_ocupado", 64'(bus.ocupado), 64'd0);
    chk("rst_concluido", 64'(bus.concluido), 64'd0);
    chk("rst_erro", 64'(bus.erro), 64'd0);
    chk("rst_ready", 64'(bus.byte_ready), 64'd1);
    repeat (10) begin
      @(negedge clock);
      chk("idle_no_strobe", 64'(bus.escrita_habilitada), 64'd0);
    end

    junk = {};
    words = {32'h00000000, 32'h7800000F};
    send_frame(junk, 2, words);

    junk = {8'h12, 8'h34};
    words = {32'hF8000000};
    send_frame(junk, 1, words);

    junk = {};
    words = {};
    send_frame(junk, 31, words);
    words = {32'hFC000000};
    send_frame(junk, 1, words);

    // Partial frame interrupted by reset: nothing may be written.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_ocupado", 64'(bus.ocupado), 64'd0);
    chk("midrst_ready", 64'(bus.byte_ready), 64'd1);
    chk("midrst_concluido", 64'(bus.concluido), 64'd0);
    chk("midrst_strobe", 64'(bus.escrita_habilitada), 64'd0);
    words = {32'hA5A5A5A5};
    send_frame(junk, 1, words);

    stream_mode = 1'b1;
    words = {};
    for (int i = 0; i < MEM_SIZE; i++) words.push_back($urandom);
    send_frame(junk, MEM_SIZE, words);

    for (int f = 0; f < 8; f++) begin
      stream_mode = ($urandom_range(0, 1) == 1);
      junk = {};
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        do b = 8'($urandom); while (b == 8'hA5);
        junk.push_back(b);
      end
      kind = int'($urandom_range(0, 3));
      if (kind == 0)      count = 0;
      else if (kind == 1) count = int'($urandom_range(MEM_SIZE + 1, 65535));
      else                count = int'($urandom_range(1, MEM_SIZE));
      words = {};
      for (int i = 0; i < count && i < MEM_SIZE; i++) words.push_back($urandom);
      send_frame(junk, count, words);
    end

    repeat (5) @(negedge clock);
    chk("final_queue_empty", 64'(exp_addr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
